// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot/reload controller.
package imem_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } imem_state_e;

    localparam int          IMEM_DEPTH  = 256;
    localparam int          IMEM_ADDR_W = 8;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

endpackage

// File: rtl/imem_boot_ctrl.sv
// Loads a program into the instruction memory, zero-fills the remainder, then
// releases the CPU and maps its byte PC onto the memory read port.
module imem_boot_ctrl
    import imem_pkg::*;
#(
    parameter int          DEPTH     = IMEM_DEPTH,
    parameter int          ADDR_W    = IMEM_ADDR_W,
    parameter logic [31:0] FILL_WORD = NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    input  logic              reload,
    input  logic [31:0]       pc,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              cpu_stall,
    output logic              pc_fault,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    imem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              load_done_q, load_done_d;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        unique case (state_q)
            LOAD: begin
                if (ld_valid) begin
                    word_count_d = word_count_q + 1'b1;
                    addr_d       = addr_q + 1'b1;
                    // A full image goes straight to RUN regardless of ld_last.
                    if (addr_q == LAST_ADDR) begin
                        state_d = RUN;
                    end else if (ld_last) begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (reload) begin
                    state_d      = LOAD;
                    addr_d       = '0;
                    word_count_d = '0;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
        load_done_d = (state_d == RUN) && (state_q != RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOAD;
            addr_q       <= '0;
            word_count_q <= '0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            load_done_q  <= load_done_d;
        end
    end

    assign ld_ready   = (state_q == LOAD);
    assign mem_we     = ((state_q == LOAD) && ld_valid) || (state_q == FILL);
    assign mem_waddr  = addr_q;
    assign mem_wdata  = (state_q == FILL) ? FILL_WORD : ld_data;
    assign mem_raddr  = pc[ADDR_W+1:2];
    assign cpu_stall  = (state_q != RUN);
    // Faults only matter once the CPU is actually fetching.
    assign pc_fault   = (state_q == RUN) &&
                        ((pc[1:0] != 2'b00) || (pc[31:ADDR_W+2] != '0));
    assign load_done  = load_done_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: expected memory writes are queued as
// stimulus is driven and checked as the controller issues them.
module tb_imem_boot_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        reload = 1'b0;
    logic [31:0] pc = '0;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_raddr;
    logic        cpu_stall;
    logic        pc_fault;
    logic        load_done;
    logic [8:0]  word_count;

    imem_boot_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .reload     (reload),
        .pc         (pc),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_raddr  (mem_raddr),
        .cpu_stall  (cpu_stall),
        .pc_fault   (pc_fault),
        .load_done  (load_done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  done_cyc = 0;
    int  done_pulses = 0;
    int  start_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Write-port monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        wr_t e;
        if (load_done === 1'b1) begin
            done_pulses++;
            done_cyc = cyc;
        end
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(mem_we), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("waddr", 64'(mem_waddr), 64'(e.a));
                chk("wdata", 64'(mem_wdata), 64'(e.d));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int a, input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        exp_q.push_back({8'(a), d});
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic push_fill(input int from, input int to);
        for (int i = from; i <= to; i++) exp_q.push_back({8'(i), 32'h0});
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (cpu_stall === 1'b0) break;
            n++;
            if (n > 400) begin
                chk({tag, "_timeout"}, 64'(cpu_stall), 64'(0));
                break;
            end
        end
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        @(negedge clk);
        chk("reload_stall", 64'(cpu_stall), 64'(1));
        chk("reload_ready", 64'(ld_ready), 64'(1));
        chk("reload_addr", 64'(mem_waddr), 64'(0));
        chk("reload_wcount", 64'(word_count), 64'(0));
        tick();
    endtask

    initial begin
        int n;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ready", 64'(ld_ready), 64'(1));
        chk("rst_stall", 64'(cpu_stall), 64'(1));
        chk("rst_we", 64'(mem_we), 64'(0));
        chk("rst_wcount", 64'(word_count), 64'(0));
        chk("rst_done", 64'(load_done), 64'(0));
        chk("rst_waddr", 64'(mem_waddr), 64'(0));
        pc = 32'h3A;
        @(negedge clk);
        chk("fault_outside_run", 64'(pc_fault), 64'(0));
        chk("raddr_in_load", 64'(mem_raddr), 64'(14));
        tick();
        reset = 1'b0;
        tick();

        // 30-word program with ld_last, followed by zero fill.
        start_cyc = cyc;
        for (int i = 0; i < 30; i++) send_word(i, $urandom, (i == 29));
        push_fill(30, 255);
        wait_run("load30");
        chk("load30_done", 64'(load_done), 64'(1));
        chk("load30_wcount", 64'(word_count), 64'(30));
        tick();
        chk("load30_latency", 64'(done_cyc - start_cyc), 64'(256));
        @(negedge clk);
        chk("load30_done_once", 64'(load_done), 64'(0));
        tick();

        // Fetch mapping and fault detection.
        pc = 32'h38;
        @(negedge clk);
        chk("pc38_raddr", 64'(mem_raddr), 64'(14));
        chk("pc38_fault", 64'(pc_fault), 64'(0));
        pc = 32'h3A;
        @(negedge clk);
        chk("pc3a_fault", 64'(pc_fault), 64'(1));
        pc = 32'h400;
        @(negedge clk);
        chk("pc400_raddr", 64'(mem_raddr), 64'(0));
        chk("pc400_fault", 64'(pc_fault), 64'(1));
        pc = 32'h0;
        tick();

        // Full 256-word image: direct LOAD->RUN.
        do_reload();
        for (int i = 0; i < 256; i++) send_word(i, $urandom, 1'b0);
        @(negedge clk);
        chk("full_run", 64'(cpu_stall), 64'(0));
        chk("full_done", 64'(load_done), 64'(1));
        chk("full_no_fill", 64'(mem_we), 64'(0));
        chk("full_wcount", 64'(word_count), 64'(256));
        tick();

        // Gapped stream, with reload ignored during FILL.
        do_reload();
        for (int i = 0; i < 4; i++) begin
            send_word(i, $urandom, (i == 3));
            if (i < 3) begin
                @(negedge clk);
                chk("gap_we", 64'(mem_we), 64'(0));
                tick();
            end
        end
        push_fill(4, 255);
        reload = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        chk("fill_reload_stall", 64'(cpu_stall), 64'(1));
        chk("fill_reload_we", 64'(mem_we), 64'(1));
        chk("fill_reload_ready", 64'(ld_ready), 64'(0));
        reload = 1'b0;
        wait_run("gap");
        chk("gap_wcount", 64'(word_count), 64'(4));
        tick();

        // Reset in the middle of FILL, then a fresh 2-word load.
        do_reload();
        send_word(0, $urandom, 1'b0);
        send_word(1, $urandom, 1'b1);
        push_fill(2, 100);
        n = 0;
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1 && mem_waddr == 8'd100) break;
            n++;
            if (n > 300) begin
                chk("fill100_timeout", 64'(mem_waddr), 64'(100));
                break;
            end
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_we", 64'(mem_we), 64'(0));
        chk("midrst_stall", 64'(cpu_stall), 64'(1));
        chk("midrst_ready", 64'(ld_ready), 64'(1));
        chk("midrst_addr", 64'(mem_waddr), 64'(0));
        chk("midrst_wcount", 64'(word_count), 64'(0));
        tick();
        send_word(0, $urandom, 1'b0);
        send_word(1, $urandom, 1'b1);
        push_fill(2, 255);
        wait_run("post_rst");
        chk("post_rst_wcount", 64'(word_count), 64'(2));
        tick();
        tick();

        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        chk("done_pulses", 64'(done_pulses), 64'(4));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Boot/reload controller for the single-cycle CPU's 256-word instruction memory. It accepts a program over a valid/ready word stream and drives the memory write port, zero-filling unused words. It holds the CPU stalled until the image is complete, then maps the CPU PC onto the memory read address and flags bad fetch addresses. It sits between the external loader, the instruction memory and the PC register.

Parameters:
DEPTH, 256, number of 32-bit instruction words
ADDR_W, 8, word-address width (log2 DEPTH)
FILL_WORD, 32'h0000_0000, value written to unloaded words (MIPS nop)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
ld_valid  in  1  loader word valid
ld_ready  out  1  controller accepts a word this cycle
ld_data  in  32  instruction word
ld_last  in  1  marks the final word of the program
reload  in  1  request a new program load (sampled in RUN only)
pc  in  32  CPU byte-address program counter
mem_we  out  1  instruction memory write enable
mem_waddr  out  ADDR_W  write word address
mem_wdata  out  32  write data
mem_raddr  out  ADDR_W  read word address = pc[ADDR_W+1:2]
cpu_stall  out  1  high: CPU must hold PC and suppress register/memory writes
pc_fault  out  1  fetch address out of range or misaligned
load_done  out  1  one-cycle pulse on entry to RUN
word_count  out  ADDR_W+1  words accepted from loader in last load (0..DEPTH)

Behaviour:
- One clock: clk. Reset is synchronous and active-high: reset.
- States: LOAD, FILL, RUN. Registers: state, addr (ADDR_W), word_count, load_done.
- Reset -> LOAD. After reset: addr=0, word_count=0, load_done=0, cpu_stall=1, ld_ready=1, mem_we=0, pc_fault=0.
- Combinational outputs:
  - ld_ready = (state==LOAD).
  - mem_we = (LOAD & ld_valid) | FILL.
  - mem_waddr = addr.
  - mem_wdata = ld_data in LOAD, FILL_WORD in FILL.
  - cpu_stall = (state!=RUN).
- LOAD, handshake on ld_valid&ld_ready: write ld_data at addr, word_count+1.
  - If addr==DEPTH-1: go to RUN. No FILL; ld_last is irrelevant.
  - Else if ld_last: go to FILL with addr+1.
  - Else addr+1 and stay in LOAD.
  - No handshake: all registers hold. Gaps in ld_valid are legal.
- FILL: one zero-fill write per cycle at addr, addr+1. Write at DEPTH-1 -> RUN. Loader words are not accepted (ld_ready=0).
- RUN:
  - mem_raddr = pc[ADDR_W+1:2].
  - pc_fault = (pc[1:0]!=0) | (pc[31:ADDR_W+2]!=0), combinational.
  - pc_fault is 0 outside RUN. mem_raddr is driven from pc in all states.
- load_done: registered, high for exactly the first RUN cycle.
- reload high in RUN -> next cycle LOAD, addr=0, word_count=0, cpu_stall=1. reload is ignored in LOAD/FILL.
- Latency: N-word program (N<DEPTH) with back-to-back valid -> RUN exactly DEPTH cycles after the first accepted word.
- Reset mid-LOAD/FILL -> LOAD with addr 0. Memory contents are not cleared; the next load overwrites them fully.
- word_count saturates naturally at DEPTH (max DEPTH writes per load).

Decomposition:
- Shared package imem_pkg: state enum {LOAD,FILL,RUN}, IMEM_DEPTH=256, IMEM_ADDR_W=8, NOP_WORD=32'h0.
- No sub-module; the single FSM plus counter is small.
- The memory array itself stays in the existing instruction memory, extended with a write port.

Test Plan:
- Reset, then stream 30 words back-to-back, ld_last on word 30 -> writes at addr 0..29, then FILL writes 30..255 with 0. load_done pulses on cycle 256 after the first word, cpu_stall falls, word_count=30.
- Stream 256 words, no ld_last -> writes 0..255, direct LOAD->RUN with zero FILL cycles, word_count=256.
- Toggle ld_valid every other cycle for 4 words + last -> mem_we only on valid cycles, addr holds during gaps, mem_waddr sequence 0,1,2,3.
- In RUN: pc=0x38 -> mem_raddr=14, pc_fault=0. pc=0x3A -> pc_fault=1. pc=0x400 -> mem_raddr=0, pc_fault=1.
- reload in RUN -> next cycle cpu_stall=1, ld_ready=1, addr=0. reload asserted during FILL -> no effect, FILL completes.
- Assert reset during FILL at addr=100 -> next cycle state LOAD, mem_we=0, addr=0, word_count=0. A new 2-word load then completes normally.
